switch_sequencer: RTL and testbench
===================================

// Module: switch_sequencer
// PURPOSE
//  Parametrised successor of the Stokes/anti-Stokes switch controller. Steps an optical/RF
//  switch through CHANNELS inputs (round-robin, ping-pong or fixed) once per completed
//  measurement block, then blanks acquisition for a settle window. Sits beside the
//  measure/point counters; switch/settle feed the optical switch driver and the accumulator.
// PARAMETERS
//  POINTS        1000   points per trace; trigger point is POINTS+TRIG_OFFSET
//  MEASURES      65536  measures per block; trigger when cnt_measure==MEASURES-1
//  TRIG_OFFSET   50     extra points after trace end before switching
//  CHANNELS      2      switch inputs, 1..16 (2 = Stokes/anti-Stokes)
//  SETTLE_CYCLES 64     clk cycles settle is held high after a switch, >=1
//  MEAS_W        17     cnt_measure width
//  PT_W          11     cnt_point width; POINTS+TRIG_OFFSET must fit
//  CH_W          max(1,$clog2(CHANNELS))  channel field width (localparam)
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous, active-high reset
//  enable      in   1       1 = sequencing active; 0 = hold channel, no triggers
//  mode        in   2       00 round-robin, 01 ping-pong, 10/11 fixed
//  fixed_ch    in   CH_W    channel used in fixed mode
//  cnt_measure in   MEAS_W  current measure index
//  cnt_point   in   PT_W    current point index
//  switch      out  CH_W    selected channel (0 = anti-Stokes, 1 = Stokes for CHANNELS=2)
//  settle      out  1       high while switch output is settling; data to be discarded
//  ch_done     out  1       1-cycle pulse on every channel change trigger
//  sweep_done  out  1       1-cycle pulse when a full sweep completes
//  overrun     out  1       sticky: trigger arrived while settle still high
// BEHAVIOUR
//  - Reset: switch=0, settle=0, ch_done=0, sweep_done=0, overrun=0, dir=up, state IDLE, trig_q=0.
//  - trig_raw = (cnt_measure==MEASURES-1) && (cnt_point==POINTS+TRIG_OFFSET); trig_q = registered
//    trig_raw; trigger = trig_raw & ~trig_q & enable (one event per entry, not per held cycle).
//  - FSM: IDLE (enable=0) -> RUN when enable=1. RUN --trigger--> SETTLE. SETTLE counts
//    SETTLE_CYCLES then -> RUN. enable=0 in any state -> IDLE next edge, settle cleared,
//    switch held, settle counter cleared.
//  - Latency: trigger seen at edge N -> switch, ch_done, sweep_done, settle visible after edge N;
//    settle high for exactly SETTLE_CYCLES cycles.
//  - Next channel (computed at trigger, mode sampled at trigger only):
//    round-robin: ch==CHANNELS-1 ? 0 : ch+1; sweep_done when wrapping to 0.
//    ping-pong: move in dir, reverse at 0 and CHANNELS-1; sweep_done on arriving at 0.
//    fixed: load fixed_ch, clamped to CHANNELS-1 if larger; sweep_done every trigger.
//  - CHANNELS=1: switch stays 0; ch_done and sweep_done pulse on every trigger.
//  - CHANNELS=2: ping-pong identical to round-robin (plain toggle).
//  - Trigger during SETTLE: ignored (no channel change, no pulses, timer not restarted);
//    overrun set, cleared only by rst.
//  - Mode change while switch > CHANNELS range impossible; mode change from ping-pong to
//    round-robin resets dir to up at the trigger.
//  - rst mid-SETTLE: all outputs to reset values on that edge, regardless of enable.
// STRUCTURE
//  - switch_pkg: mode encodings (MODE_RR=2'b00, MODE_PP=2'b01, MODE_FIX=2'b10), FSM state enum.
//  - Sub-module settle_timer (load, count down SETTLE_CYCLES, busy output) instantiated once.
//  - Trigger detect, next-channel logic and FSM in switch_sequencer.
// TESTING
//  1 CHANNELS=2, mode=00: drive counters to (MEASURES-1, 1050) for 3 cycles -> one trigger,
//    switch 0->1, ch_done one pulse, settle high 64 cycles, no sweep_done; next block -> 1->0, sweep_done.
//  2 CHANNELS=4, mode=01: 7 triggers -> switch 1,2,3,2,1,0,1; sweep_done only on arrival at 0.
//  3 CHANNELS=4, mode=10, fixed_ch=3 then 6 (CH_W=2 so 6 wraps to 2 at port) -> switch 3 then 2.
//  4 SETTLE_CYCLES=64: second trigger 10 cycles after first -> switch unchanged, overrun=1 sticky.
//  5 enable=0 during SETTLE -> settle 0 next cycle, switch held; trigger while disabled -> no change.
//  6 rst at settle cycle 20 with switch=1 -> switch=0, settle=0, overrun=0 on next cycle.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared definitions for the switch sequencer: mode encodings and FSM state type.
package switch_pkg;

  localparam logic [1:0] MODE_RR  = 2'b00;
  localparam logic [1:0] MODE_PP  = 2'b01;
  localparam logic [1:0] MODE_FIX = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StSettle
  } state_e;

endpackage

// File: rtl/settle_timer.sv
// Down-counter holding busy high for CYCLES clocks after load.
module settle_timer #(
  parameter int unsigned CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  output logic busy,
  output logic last
);

  localparam int unsigned CntW = $clog2(CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = CntW'(CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);
  // High on the final busy cycle so the FSM leaves settle in step with busy falling.
  assign last = (cnt_q == CntW'(1));

endmodule

// File: rtl/switch_sequencer.sv
// Steps the optical/RF switch through its inputs once per measurement block, then
// blanks acquisition for a settle window.
module switch_sequencer
  import switch_pkg::*;
#(
  parameter int unsigned POINTS        = 1000,
  parameter int unsigned MEASURES      = 65536,
  parameter int unsigned TRIG_OFFSET   = 50,
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned MEAS_W        = 17,
  parameter int unsigned PT_W          = 11,
  localparam int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [CH_W-1:0]   fixed_ch,
  input  logic [MEAS_W-1:0] cnt_measure,
  input  logic [PT_W-1:0]   cnt_point,
  output logic [CH_W-1:0]   switch,
  output logic              settle,
  output logic              ch_done,
  output logic              sweep_done,
  output logic              overrun
);

  localparam logic [MEAS_W-1:0] LastMeas  = MEAS_W'(MEASURES - 1);
  localparam logic [PT_W-1:0]   TrigPoint = PT_W'(POINTS + TRIG_OFFSET);
  localparam logic [CH_W-1:0]   LastCh    = CH_W'(CHANNELS - 1);

  state_e          state_q, state_d;
  logic            trig_q;
  logic [CH_W-1:0] ch_q, ch_d, nxt_ch;
  logic            dir_q, dir_d, nxt_dir;  // 1 = counting up
  logic            ch_done_q, ch_done_d;
  logic            sweep_q, sweep_d, nxt_sweep;
  logic            overrun_q, overrun_d;
  logic            trig_raw, trigger;
  logic            tmr_load, tmr_clear, tmr_busy, tmr_last;

  assign trig_raw = (cnt_measure == LastMeas) && (cnt_point == TrigPoint);
  // Rising edge only: a held trigger condition yields a single event.
  assign trigger  = trig_raw & ~trig_q & enable;

  always_comb begin
    nxt_ch    = ch_q;
    nxt_dir   = dir_q;
    nxt_sweep = 1'b0;
    if (CHANNELS == 1) begin
      nxt_ch    = '0;
      nxt_sweep = 1'b1;
    end else begin
      case (mode)
        MODE_RR: begin
          nxt_dir   = 1'b1;
          nxt_ch    = (ch_q >= LastCh) ? '0 : ch_q + 1'b1;
          nxt_sweep = (ch_q >= LastCh);
        end
        MODE_PP: begin
          if (dir_q && (ch_q >= LastCh)) begin
            nxt_ch  = ch_q - 1'b1;
            nxt_dir = 1'b0;
          end else if (!dir_q && (ch_q == '0)) begin
            nxt_ch  = ch_q + 1'b1;
            nxt_dir = 1'b1;
          end else if (dir_q) begin
            nxt_ch = ch_q + 1'b1;
          end else begin
            nxt_ch = ch_q - 1'b1;
          end
          nxt_sweep = (nxt_ch == '0);
        end
        default: begin
          nxt_ch    = (fixed_ch > LastCh) ? LastCh : fixed_ch;
          nxt_sweep = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    dir_d     = dir_q;
    ch_done_d = 1'b0;
    sweep_d   = 1'b0;
    overrun_d = overrun_q;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    if (!enable) begin
      state_d   = StIdle;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        StIdle: state_d = StRun;
        StRun: begin
          if (trigger) begin
            state_d   = StSettle;
            tmr_load  = 1'b1;
            ch_d      = nxt_ch;
            dir_d     = nxt_dir;
            ch_done_d = 1'b1;
            sweep_d   = nxt_sweep;
          end
        end
        StSettle: begin
          if (trigger) overrun_d = 1'b1;
          if (tmr_last) state_d = StRun;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      trig_q    <= 1'b0;
      ch_q      <= '0;
      dir_q     <= 1'b1;
      ch_done_q <= 1'b0;
      sweep_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      trig_q    <= trig_raw;
      ch_q      <= ch_d;
      dir_q     <= dir_d;
      ch_done_q <= ch_done_d;
      sweep_q   <= sweep_d;
      overrun_q <= overrun_d;
    end
  end

  settle_timer #(
    .CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(tmr_clear),
    .load (tmr_load),
    .busy (tmr_busy),
    .last (tmr_last)
  );

  assign switch     = ch_q;
  assign settle     = tmr_busy;
  assign ch_done    = ch_done_q;
  assign sweep_done = sweep_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_switch_sequencer.sv
// Randomised scoreboard bench: two sequencers (2 and 4 channels) share stimulus and are
// compared against a behavioural model of the channel-stepping rules.
module tb_switch_sequencer;

  localparam int unsigned Points   = 1000;
  localparam int unsigned Measures = 65536;
  localparam int unsigned Offset   = 50;
  localparam int          Settle   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        fixed2 = 1'b0;
  logic [1:0]  fixed4 = 2'b00;
  logic [16:0] cnt_measure = '0;
  logic [10:0] cnt_point = '0;

  logic       sw2, settle2, done2, sweep2, ovr2;
  logic [1:0] sw4;
  logic       settle4, done4, sweep4, ovr4;

  always #5 clk = ~clk;

  switch_sequencer #(.CHANNELS(2)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .fixed_ch   (fixed2),
    .cnt_measure(cnt_measure),
    .cnt_point  (cnt_point),
    .switch     (sw2),
    .settle     (settle2),
    .ch_done    (done2),
    .sweep_done (sweep2),
    .overrun    (ovr2)
  );

  switch_sequencer #(.CHANNELS(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .fixed_ch   (fixed4),
    .cnt_measure(cnt_measure),
    .cnt_point  (cnt_point),
    .switch     (sw4),
    .settle     (settle4),
    .ch_done    (done4),
    .sweep_done (sweep4),
    .overrun    (ovr4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, index 0 = 2 channels, index 1 = 4 channels.
  int m_ch[2]   = '{0, 0};
  int m_dir[2]  = '{1, 1};
  int m_left[2] = '{0, 0};
  bit m_ovr[2]  = '{0, 0};
  bit m_act[2]  = '{0, 0};
  bit m_prev    = 1'b0;
  int q0[$];
  int q1[$];

  int m_c, m_f, m_e;
  bit m_hit, m_trig, m_sweep;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_hit  = (cnt_measure == 17'(Measures - 1)) && (cnt_point == 11'(Points + Offset));
    m_trig = m_hit && !m_prev && enable;
    m_prev = rst ? 1'b0 : m_hit;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_ch[k] = 0; m_dir[k] = 1; m_left[k] = 0; m_ovr[k] = 0; m_act[k] = 0;
      end else if (!enable) begin
        m_act[k]  = 0;
        m_left[k] = 0;
      end else if (!m_act[k]) begin
        m_act[k] = 1;
      end else if (m_left[k] > 0) begin
        if (m_trig) m_ovr[k] = 1;
        m_left[k]--;
      end else if (m_trig) begin
        m_c = (k == 0) ? 2 : 4;
        m_f = (k == 0) ? int'(fixed2) : int'(fixed4);
        if (mode == 2'b00) begin
          m_ch[k]  = (m_ch[k] + 1) % m_c;
          m_dir[k] = 1;
          m_sweep  = (m_ch[k] == 0);
        end else if (mode == 2'b01) begin
          if (m_ch[k] == m_c - 1) m_dir[k] = -1;
          else if (m_ch[k] == 0) m_dir[k] = 1;
          m_ch[k] = m_ch[k] + m_dir[k];
          m_sweep = (m_ch[k] == 0);
        end else begin
          m_ch[k] = (m_f > m_c - 1) ? m_c - 1 : m_f;
          m_sweep = 1'b1;
        end
        if (k == 0) q0.push_back(m_ch[k] * 2 + int'(m_sweep));
        else        q1.push_back(m_ch[k] * 2 + int'(m_sweep));
        m_left[k] = Settle;
      end
    end
  end

  task automatic monitor(input int k, input int sw, input bit st, input bit dn, input bit swp,
                         input bit ov);
    int depth, e;
    string tag;
    tag   = (k == 0) ? "ch2" : "ch4";
    depth = (k == 0) ? q0.size() : q1.size();
    check({tag, "_switch"}, sw, m_ch[k]);
    check({tag, "_settle"}, int'(st), int'(m_left[k] > 0));
    check({tag, "_overrun"}, int'(ov), int'(m_ovr[k]));
    if (dn) begin
      check({tag, "_ch_done_expected"}, depth, 1);
      if (depth > 0) begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check({tag, "_event_switch"}, sw, e / 2);
        check({tag, "_event_sweep_done"}, int'(swp), e % 2);
      end
    end else begin
      check({tag, "_ch_done_missing"}, depth, 0);
      check({tag, "_sweep_without_done"}, int'(swp), 0);
      if (k == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  always @(negedge clk) begin
    monitor(0, int'(sw2), settle2, done2, sweep2, ovr2);
    monitor(1, int'(sw4), settle4, done4, sweep4, ovr4);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cnt_measure = 17'($urandom_range(0, Measures - 2));
      cnt_point   = 11'($urandom_range(0, 2047));
    end
  endtask

  task automatic drive_hit(input int n);
    repeat (n) begin
      @(negedge clk);
      cnt_measure = 17'(Measures - 1);
      cnt_point   = 11'(Points + Offset);
    end
  endtask

  task automatic block(input int gap);
    drive_hit(int'($urandom_range(1, 3)));
    idle(gap);
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    enable = 1'b1;
    idle(5);
    // Round-robin: 0->1 then 1->0 with sweep on the 2-channel unit
    mode = 2'b00;
    block(80);
    block(80);
    // Ping-pong through both ends
    mode = 2'b01;
    repeat (7) block(80);
    // Fixed channel, including an out-of-range request
    mode = 2'b10;
    fixed4 = 2'd3; fixed2 = 1'b1;
    block(80);
    fixed4 = 2'(6); fixed2 = 1'b0;
    block(80);
    // Second trigger inside the settle window
    mode = 2'b00;
    drive_hit(1); idle(10); drive_hit(1); idle(80);
    // Disable during settle, trigger while disabled
    drive_hit(1); idle(20);
    enable = 1'b0;
    idle(3); drive_hit(2); idle(3);
    enable = 1'b1;
    idle(5);
    block(80);
    // Reset in the middle of settle
    drive_hit(1); idle(20);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    idle(5);
    // Randomised blocks
    repeat (150) begin
      mode   = 2'($urandom_range(0, 3));
      fixed4 = 2'($urandom_range(0, 3));
      fixed2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        enable = 1'b0;
        idle(int'($urandom_range(1, 4)));
        enable = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) begin
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) block(int'($urandom_range(1, 70)));
      else                           block(int'($urandom_range(64, 90)));
    end
    idle(80);
    check("ch2_queue_drained", q0.size(), 0);
    check("ch4_queue_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
